wps_pingpong_buf: RTL

//  Two-bank ping-pong line buffer directly upstream of the WPS frame sender.
//  - Write side: accepts 24-bit pixel words from the DMA/unpacker stream.
//  - Read side: serves the sender's per-DE read strobe with fixed 1-cycle latency.
//  - One bank fills while the other drains; the sender's wait-for-data handshake keys off `ready`.

---
 rtl/wps_pingpong_buf.sv | 121 ++++++++++++
 1 files changed

// File: rtl/wps_pingpong_buf.sv
// Two-bank ping-pong line buffer feeding the WPS frame sender: one bank fills while the other drains.
// Optional build macro WPS_PP_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module wps_pingpong_buf #(
    parameter int DATA_W     = 24,
    parameter int BANK_DEPTH = 80,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic [1:0]        full_banks,
    output logic              underrun
`ifdef WPS_PP_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int MEM_DEPTH = 2 * BANK_DEPTH;
    localparam int MEM_AW    = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);
    localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(BANK_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        bank_full;
    logic [1:0]        bank_full_nxt;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_last;
    logic              rd_last;

    assign wr_ready   = ~bank_full[wr_bank];
    assign ready      = bank_full[rd_bank];
    assign full_banks = {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

    assign wr_fire = wr_valid & wr_ready;
    assign rd_fire = rd_en & ready;
    assign wr_last = (wr_addr == LAST_ADDR);
    assign rd_last = (rd_addr == LAST_ADDR);

    // Banks are packed back to back so the RAM stays exactly 2*BANK_DEPTH deep.
    assign wr_idx = wr_bank ? (BANK1_BASE + MEM_AW'(wr_addr)) : MEM_AW'(wr_addr);
    assign rd_idx = rd_bank ? (BANK1_BASE + MEM_AW'(rd_addr)) : MEM_AW'(rd_addr);

    // Fill and drain always touch different banks, so both bits can change in one cycle.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_fire && wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && wr_fire) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            bank_full <= 2'b00;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_idx];
                if (rd_last) begin
                    rd_addr <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end else if (rd_en) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef WPS_PP_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            underrun_cnt <= '0;
        end else if (rd_en && !ready && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
